// File: rtl/pointwise_sched.sv
// Pointwise (1x1) convolution tile scheduler: walks input/output channel tiles
// for each pixel and tracks the matching results through the compute pipe.
module pointwise_sched #(
   parameter int INCHANNEL_PARALLELISM  = 8,
   parameter int OUTCHANNEL_PARALLELISM = 8,
   parameter int PIPE_DEPTH             = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] output_size,
   input  logic [7:0] input_channel,
   input  logic [7:0] output_channel,
   input  logic       pix_valid,
   output logic       pix_ack,
   output logic       issue,
   output logic [7:0] input_channel_sel,
   output logic [7:0] output_channel_sel,
   output logic       res_valid,
   output logic [7:0] res_ic_sel,
   output logic [7:0] res_oc_sel,
   output logic       res_first_ic,
   output logic       pixel_done,
   output logic [7:0] out_h,
   output logic [7:0] out_w,
   output logic       busy,
   output logic       done
);

   localparam logic [9:0] ICP_W        = 10'(INCHANNEL_PARALLELISM);
   localparam logic [9:0] OCP_W        = 10'(OUTCHANNEL_PARALLELISM);
   localparam logic [7:0] DRAIN_CYCLES = 8'(PIPE_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT_PIX, ISSUE, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [7:0]  size_q, size_d;
   logic [7:0]  inCh_q, inCh_d;
   logic [7:0]  outCh_q, outCh_d;
   logic [15:0] totPixM1_q, totPixM1_d;
   logic [15:0] pixCnt_q, pixCnt_d;
   logic [7:0]  icSel_q, icSel_d;
   logic [7:0]  ocSel_q, ocSel_d;
   logic [7:0]  outH_q, outH_d;
   logic [7:0]  outW_q, outW_d;
   logic [7:0]  drainCnt_q, drainCnt_d;

   logic [PIPE_DEPTH-1:0]      pipeValid_q, pipeLast_q;
   logic [PIPE_DEPTH-1:0][7:0] pipeIc_q, pipeOc_q;

   logic lastIc, lastOc, lastPix, pipeBusy;

   // A zero channel count still satisfies the compare on the first tile, so it behaves as one tile.
   assign lastIc   = ({2'b00, icSel_q} + ICP_W) >= {2'b00, inCh_q};
   assign lastOc   = ({2'b00, ocSel_q} + OCP_W) >= {2'b00, outCh_q};
   assign lastPix  = (pixCnt_q == totPixM1_q);
   assign pipeBusy = |pipeValid_q;

   assign input_channel_sel  = icSel_q;
   assign output_channel_sel = ocSel_q;
   assign res_valid          = pipeValid_q[PIPE_DEPTH-1];
   assign res_ic_sel         = pipeIc_q[PIPE_DEPTH-1];
   assign res_oc_sel         = pipeOc_q[PIPE_DEPTH-1];
   assign res_first_ic       = res_valid && (res_ic_sel == 8'd0);
   assign pixel_done         = res_valid && pipeLast_q[PIPE_DEPTH-1];
   assign out_h              = outH_q;
   assign out_w              = outW_q;
   assign busy               = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      inCh_d     = inCh_q;
      outCh_d    = outCh_q;
      totPixM1_d = totPixM1_q;
      pixCnt_d   = pixCnt_q;
      icSel_d    = icSel_q;
      ocSel_d    = ocSel_q;
      outH_d     = outH_q;
      outW_d     = outW_q;
      drainCnt_d = drainCnt_q;
      issue      = 1'b0;
      pix_ack    = 1'b0;
      done       = 1'b0;

      if (pixel_done) begin
         if (outW_q == size_q - 8'd1) begin
            outW_d = 8'd0;
            outH_d = (outH_q == size_q - 8'd1) ? 8'd0 : outH_q + 8'd1;
         end else begin
            outW_d = outW_q + 8'd1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               size_d     = output_size;
               inCh_d     = input_channel;
               outCh_d    = output_channel;
               totPixM1_d = 16'(output_size) * 16'(output_size) - 16'd1;
               pixCnt_d   = 16'd0;
               icSel_d    = 8'd0;
               ocSel_d    = 8'd0;
               outH_d     = 8'd0;
               outW_d     = 8'd0;
               drainCnt_d = 8'd0;
               state_d    = (output_size == 8'd0) ? DRAIN : WAIT_PIX;
            end
         end
         WAIT_PIX: begin
            if (pix_valid) state_d = ISSUE;
         end
         ISSUE: begin
            issue = 1'b1;
            if (lastIc) begin
               icSel_d = 8'd0;
               if (lastOc) begin
                  ocSel_d    = 8'd0;
                  pix_ack    = 1'b1;
                  pixCnt_d   = pixCnt_q + 16'd1;
                  drainCnt_d = 8'd0;
                  state_d    = lastPix ? DRAIN : WAIT_PIX;
               end else begin
                  ocSel_d = ocSel_q + OCP_W[7:0];
               end
            end else begin
               icSel_d = icSel_q + ICP_W[7:0];
            end
         end
         DRAIN: begin
            if (drainCnt_q >= DRAIN_CYCLES && !pipeBusy) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (drainCnt_q < DRAIN_CYCLES) begin
               drainCnt_d = drainCnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         size_q     <= 8'd0;
         inCh_q     <= 8'd0;
         outCh_q    <= 8'd0;
         totPixM1_q <= 16'd0;
         pixCnt_q   <= 16'd0;
         icSel_q    <= 8'd0;
         ocSel_q    <= 8'd0;
         outH_q     <= 8'd0;
         outW_q     <= 8'd0;
         drainCnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         inCh_q     <= inCh_d;
         outCh_q    <= outCh_d;
         totPixM1_q <= totPixM1_d;
         pixCnt_q   <= pixCnt_d;
         icSel_q    <= icSel_d;
         ocSel_q    <= ocSel_d;
         outH_q     <= outH_d;
         outW_q     <= outW_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   // Result pipe mirrors the compute engine latency; idle slots carry zero selects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipeValid_q <= '0;
         pipeLast_q  <= '0;
         pipeIc_q    <= '0;
         pipeOc_q    <= '0;
      end else begin
         pipeValid_q[0] <= issue;
         pipeLast_q[0]  <= issue && lastIc && lastOc;
         pipeIc_q[0]    <= issue ? icSel_q : 8'd0;
         pipeOc_q[0]    <= issue ? ocSel_q : 8'd0;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipeValid_q[i] <= pipeValid_q[i-1];
            pipeLast_q[i]  <= pipeLast_q[i-1];
            pipeIc_q[i]    <= pipeIc_q[i-1];
            pipeOc_q[i]    <= pipeOc_q[i-1];
         end
      end
   end

endmodule

// File: tb/tb_pointwise_sched.sv
// Self-checking bench for pointwise_sched: a tile/pixel reference model predicts
// every issue, result and position, with directed and randomized passes.
module tb_pointwise_sched;

   localparam int ICP = 8;
   localparam int OCP = 8;
   localparam int PD  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] output_size, input_channel, output_channel;
   logic       pix_valid;
   logic       pix_ack, issue, res_valid, res_first_ic, pixel_done, busy, done;
   logic [7:0] input_channel_sel, output_channel_sel, res_ic_sel, res_oc_sel, out_h, out_w;

   int compared   = 0;
   int mismatched = 0;
   int cycle      = 0;

   typedef struct {
      int cyc;
      int ic;
      int oc;
      bit last;
      int pix;
   } rec_t;

   pointwise_sched #(
      .INCHANNEL_PARALLELISM(ICP),
      .OUTCHANNEL_PARALLELISM(OCP),
      .PIPE_DEPTH(PD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .output_size(output_size), .input_channel(input_channel), .output_channel(output_channel),
      .pix_valid(pix_valid), .pix_ack(pix_ack), .issue(issue),
      .input_channel_sel(input_channel_sel), .output_channel_sel(output_channel_sel),
      .res_valid(res_valid), .res_ic_sel(res_ic_sel), .res_oc_sel(res_oc_sel),
      .res_first_ic(res_first_ic), .pixel_done(pixel_done),
      .out_h(out_h), .out_w(out_w), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_issue"}, issue, 0);
      checkOutput({tag, "_pix_ack"}, pix_ack, 0);
      checkOutput({tag, "_res_valid"}, res_valid, 0);
      checkOutput({tag, "_pixel_done"}, pixel_done, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_ic_sel"}, input_channel_sel, 0);
      checkOutput({tag, "_oc_sel"}, output_channel_sel, 0);
      checkOutput({tag, "_res_ic"}, res_ic_sel, 0);
      checkOutput({tag, "_res_oc"}, res_oc_sel, 0);
      checkOutput({tag, "_first_ic"}, res_first_ic, 0);
      checkOutput({tag, "_out_h"}, out_h, 0);
      checkOutput({tag, "_out_w"}, out_w, 0);
   endtask

   // validMode: 0 = pix_valid always high, 1 = random, 2 = low for 10 cycles after start.
   task automatic applyStimulus(input int size, input int inCh, input int outCh,
                                input int validMode, input bit restart);
      int nic, noc, ntiles, total, tileIdx, pixIssued, s, c, lastIssue, ackCnt, pdCnt, ic, oc;
      bit prevWait, prevValid, expIssue, expRes, waitNow, finished, last;
      rec_t inflight[$];
      rec_t r;
      nic       = (inCh == 0) ? 1 : (inCh + ICP - 1) / ICP;
      noc       = (outCh == 0) ? 1 : (outCh + OCP - 1) / OCP;
      ntiles    = nic * noc;
      total     = size * size;
      tileIdx   = 0;
      pixIssued = 0;
      lastIssue = 0;
      ackCnt    = 0;
      pdCnt     = 0;
      prevWait  = 1'b0;
      finished  = 1'b0;
      $display("[TB] pass size=%0d in=%0d out=%0d mode=%0d restart=%0d", size, inCh, outCh, validMode, restart);
      @(negedge clk);
      s              = cycle;
      output_size    = 8'(size);
      input_channel  = 8'(inCh);
      output_channel = 8'(outCh);
      start          = 1'b1;
      pix_valid      = (validMode == 0) ? 1'b1 : (validMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      prevValid      = pix_valid;
      for (int k = 0; k < 20000 && !finished; k++) begin
         @(negedge clk);
         c        = cycle;
         expIssue = (pixIssued < total) && (tileIdx > 0 || (prevWait && prevValid));
         waitNow  = (pixIssued < total) && !expIssue;
         ic       = (tileIdx % nic) * ICP;
         oc       = (tileIdx / nic) * OCP;
         last     = (tileIdx == ntiles - 1);
         checkOutput("busy", busy, 1);
         checkOutput("issue", issue, expIssue);
         if (expIssue) begin
            checkOutput("ic_sel", input_channel_sel, ic);
            checkOutput("oc_sel", output_channel_sel, oc);
            checkOutput("pix_ack", pix_ack, last);
         end else begin
            checkOutput("pix_ack_idle", pix_ack, 0);
         end
         if (pix_ack === 1'b1) ackCnt++;
         expRes = (inflight.size() > 0) && (inflight[0].cyc + PD == c);
         checkOutput("res_valid", res_valid, expRes);
         if (expRes) begin
            r = inflight.pop_front();
            checkOutput("res_ic_sel", res_ic_sel, r.ic);
            checkOutput("res_oc_sel", res_oc_sel, r.oc);
            checkOutput("res_first_ic", res_first_ic, r.ic == 0);
            checkOutput("pixel_done", pixel_done, r.last);
            checkOutput("out_h", out_h, r.pix / size);
            checkOutput("out_w", out_w, r.pix % size);
         end else begin
            checkOutput("pixel_done_idle", pixel_done, 0);
         end
         if (pixel_done === 1'b1) pdCnt++;
         if (done === 1'b1) begin
            finished = 1'b1;
            if (total == 0) begin
               checkOutput("done_size0_latency", c - s, PD + 1);
            end else begin
               checkOutput("done_after_pixels", pdCnt, total);
               checkOutput("done_not_early", c >= lastIssue + PD, 1);
               checkOutput("done_not_late", c <= lastIssue + PD + 1, 1);
            end
         end
         if (expIssue) begin
            inflight.push_back('{c, ic, oc, last, pixIssued});
            lastIssue = c;
            tileIdx++;
            if (tileIdx == ntiles) begin
               tileIdx = 0;
               pixIssued++;
            end
         end
         prevWait = waitNow;
         if (!finished) begin
            if (restart && c == s + 4) begin
               start       = 1'b1;
               output_size = 8'd0;
            end else begin
               start       = 1'b0;
               output_size = 8'($urandom);
            end
            input_channel  = 8'($urandom);
            output_channel = 8'($urandom);
            pix_valid = (validMode == 0) ? 1'b1 :
                        (validMode == 1) ? 1'($urandom_range(0, 1)) : 1'(c >= s + 11);
         end
         prevValid = pix_valid;
      end
      start = 1'b0;
      checkOutput("pass_finished", finished, 1);
      checkOutput("pix_ack_count", ackCnt, total);
      checkOutput("pixel_done_count", pdCnt, total);
      checkOutput("results_drained", inflight.size(), 0);
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
   endtask

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      pix_valid      = 1'b0;
      output_size    = 8'd0;
      input_channel  = 8'd0;
      output_channel = 8'd0;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;

      applyStimulus(2, 16, 32, 0, 1'b0);
      applyStimulus(3, 8, 8, 0, 1'b0);
      applyStimulus(2, 20, 12, 0, 1'b0);
      applyStimulus(2, 16, 16, 2, 1'b0);
      applyStimulus(2, 16, 8, 0, 1'b1);
      applyStimulus(0, 16, 16, 0, 1'b0);
      applyStimulus(1, 255, 255, 0, 1'b0);
      applyStimulus(1, 0, 0, 0, 1'b1);
      for (int r = 0; r < 6; r++) begin
         applyStimulus($urandom_range(1, 3), $urandom_range(0, 64), $urandom_range(0, 64), 1, 1'(r % 2));
      end

      // Abort a pass while tiles are in flight, then confirm a clean restart.
      @(negedge clk);
      output_size    = 8'd2;
      input_channel  = 8'd16;
      output_channel = 8'd32;
      pix_valid      = 1'b1;
      start          = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 50 && issue !== 1'b1; k++) @(negedge clk);
      checkOutput("pre_reset_issue", issue, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkAllZero("mid_reset");
      @(negedge clk);
      checkAllZero("held_reset");
      rst_n = 1'b1;
      applyStimulus(2, 16, 32, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
